decode: RTL and testbench



---
 rtl/decode_pkg.sv | 102 ++++++++++
 rtl/decode_regfile.sv | 32 +++
 rtl/decode.sv | 161 ++++++++++++++++
 tb/tb_decode.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared decode definitions: opcodes, destination selects,
// instruction field positions and the operand bundle type.
package decode_pkg;

  localparam int OP_HI  = 31;
  localparam int OP_LO  = 26;
  localparam int RS_HI  = 25;
  localparam int RS_LO  = 21;
  localparam int RT_HI  = 20;
  localparam int RT_LO  = 16;
  localparam int RD_HI  = 15;
  localparam int RD_LO  = 11;
  localparam int IMM_HI = 15;
  localparam int TGT_HI = 25;
  localparam int FN_HI  = 5;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0A;
  localparam logic [5:0] OP_SLTIU  = 6'h0B;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_XORI   = 6'h0E;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  localparam logic [5:0] OP_LB     = 6'h20;
  localparam logic [5:0] OP_LH     = 6'h21;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_LBU    = 6'h24;
  localparam logic [5:0] OP_LHU    = 6'h25;
  localparam logic [5:0] OP_SB     = 6'h28;
  localparam logic [5:0] OP_SH     = 6'h29;
  localparam logic [5:0] OP_SW     = 6'h2B;

  typedef enum logic [1:0] {
    WSEL_NONE = 2'b00,
    WSEL_RD   = 2'b01,
    WSEL_RT   = 2'b10,
    WSEL_R31  = 2'b11
  } wsel_t;

  typedef enum logic [2:0] {
    CL_R, CL_J, CL_JAL, CL_BR,
    CL_LD, CL_ST, CL_ALUI, CL_UNK
  } iclass_t;

  typedef enum logic [1:0] {
    S_IDLE, S_READ, S_OUT
  } state_t;

  typedef struct packed {
    logic [5:0]  exec_command;
    logic [5:0]  alu_command;
    logic [28:0] addr;
    logic [31:0] rs;
    logic [31:0] rt;
    wsel_t       wsel;
    logic [31:0] data;
    logic [4:0]  rd;
  } dec_out_t;

  function automatic iclass_t classify(
    input logic [5:0] op
  );
    iclass_t c;
    c = CL_UNK;
    unique case (op)
      OP_RTYPE: c = CL_R;
      OP_J:     c = CL_J;
      OP_JAL:   c = CL_JAL;
      OP_REGIMM, OP_BEQ, OP_BNE,
      OP_BLEZ, OP_BGTZ:
        c = CL_BR;
      OP_ADDI, OP_ADDIU, OP_SLTI,
      OP_SLTIU, OP_ANDI, OP_ORI,
      OP_XORI, OP_LUI:
        c = CL_ALUI;
      OP_LB, OP_LH, OP_LW,
      OP_LBU, OP_LHU:
        c = CL_LD;
      OP_SB, OP_SH, OP_SW:
        c = CL_ST;
      default: c = CL_UNK;
    endcase
    return c;
  endfunction

  function automatic logic is_zext(
    input logic [5:0] op
  );
    return (op == OP_ANDI) || (op == OP_ORI)
        || (op == OP_XORI) || (op == OP_LUI);
  endfunction

endpackage

// File: rtl/decode_regfile.sv
// 32x32 general register file: two async read ports,
// one sync write port, r0 hard-wired to zero.
module decode_regfile
  import decode_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic [4:0]  ra,
  input  logic [4:0]  rb,
  output logic [31:0] qa,
  output logic [31:0] qb,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);

  logic [31:0] mem [32];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < 32; i++) begin
        mem[i] <= '0;
      end
    end else if (we && (wa != 5'd0)) begin
      mem[wa] <= wd;
    end
  end

  assign qa = (ra == 5'd0) ? 32'h0 : mem[ra];
  assign qb = (rb == 5'd0) ? 32'h0 : mem[rb];

endmodule

// File: rtl/decode.sv
// Decode / register-read stage: latches one instruction,
// reads operands with write-back bypass, registers the bundle.
module decode
  import decode_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        enable,
  input  logic [31:0] instr,
  output logic        done,
  output logic [5:0]  exec_command,
  output logic [5:0]  alu_command,
  output logic [28:0] addr,
  output logic [31:0] rs,
  output logic [31:0] rt,
  output logic [1:0]  wselector,
  output logic [31:0] data,
  output logic [4:0]  rd,
  input  logic        wenable,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata
);

  state_t      state;
  state_t      state_nx;
  logic [31:0] ir;
  logic [5:0]  op;
  logic [4:0]  rs_i;
  logic [4:0]  rt_i;
  logic [4:0]  rd_i;
  logic [15:0] imm;
  logic [25:0] target;
  logic [5:0]  funct;
  iclass_t     cls;
  logic [31:0] rf_rs;
  logic [31:0] rf_rt;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        wb_live;
  logic [31:0] sext;
  logic [28:0] ea;
  dec_out_t    nxt;
  dec_out_t    q;

  assign op     = ir[OP_HI:OP_LO];
  assign rs_i   = ir[RS_HI:RS_LO];
  assign rt_i   = ir[RT_HI:RT_LO];
  assign rd_i   = ir[RD_HI:RD_LO];
  assign imm    = ir[IMM_HI:0];
  assign target = ir[TGT_HI:0];
  assign funct  = ir[FN_HI:0];
  assign cls    = classify(op);

  decode_regfile u_rf (
    .clk  (clk),
    .rstn (rstn),
    .ra   (rs_i),
    .rb   (rt_i),
    .qa   (rf_rs),
    .qb   (rf_rt),
    .we   (wenable),
    .wa   (waddr),
    .wd   (wdata)
  );

  // Same-cycle write-back wins over the array contents.
  assign wb_live = wenable && (waddr != 5'd0);
  assign rs_val  = (wb_live && waddr == rs_i) ? wdata : rf_rs;
  assign rt_val  = (wb_live && waddr == rt_i) ? wdata : rf_rt;

  always_ff @(posedge clk) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (enable) state_nx = S_READ;
      S_READ:  state_nx = S_OUT;
      S_OUT:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ir <= '0;
    end else if (state == S_IDLE && enable) begin
      ir <= instr;
    end
  end

  // Address math only needs 29 bits; the add wraps there.
  assign sext = {{16{imm[15]}}, imm};
  assign ea   = rs_val[28:0] + sext[28:0];

  always_comb begin
    nxt              = '0;
    nxt.exec_command = op;
    nxt.rs           = rs_val;
    nxt.rt           = rt_val;
    nxt.wsel         = WSEL_NONE;
    unique case (cls)
      CL_R: begin
        nxt.alu_command = funct;
        nxt.wsel        = WSEL_RD;
        nxt.rd          = rd_i;
      end
      CL_J: begin
        nxt.addr = {3'b000, target};
      end
      CL_JAL: begin
        nxt.addr = {3'b000, target};
        nxt.wsel = WSEL_R31;
        nxt.rd   = 5'd31;
      end
      CL_BR: begin
        nxt.data = sext;
        nxt.addr = sext[28:0];
      end
      CL_LD: begin
        nxt.data = sext;
        nxt.addr = ea;
        nxt.wsel = WSEL_RT;
        nxt.rd   = rt_i;
      end
      CL_ST: begin
        nxt.data = sext;
        nxt.addr = ea;
      end
      CL_ALUI: begin
        nxt.data = is_zext(op) ? {16'h0, imm} : sext;
        nxt.wsel = WSEL_RT;
        nxt.rd   = rt_i;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      q    <= '0;
      done <= 1'b0;
    end else begin
      done <= (state == S_READ);
      if (state == S_READ) q <= nxt;
    end
  end

  assign exec_command = q.exec_command;
  assign alu_command  = q.alu_command;
  assign addr         = q.addr;
  assign rs           = q.rs;
  assign rt           = q.rt;
  assign wselector    = q.wsel;
  assign data         = q.data;
  assign rd           = q.rd;

endmodule

// File: tb/tb_decode.sv
// Self-checking bench for decode: directed cases plus
// randomized instructions against a behavioural model.
module tb_decode;

  logic        clk = 1'b0;
  logic        rstn;
  logic        enable;
  logic [31:0] instr;
  logic        done;
  logic [5:0]  exec_command;
  logic [5:0]  alu_command;
  logic [28:0] addr;
  logic [31:0] rs;
  logic [31:0] rt;
  logic [1:0]  wselector;
  logic [31:0] data;
  logic [4:0]  rd;
  logic        wenable;
  logic [4:0]  waddr;
  logic [31:0] wdata;

  int tests = 0;
  int fails = 0;
  logic [31:0] gpr [32];

  always #5 clk = ~clk;

  decode dut (
    .clk          (clk),
    .rstn         (rstn),
    .enable       (enable),
    .instr        (instr),
    .done         (done),
    .exec_command (exec_command),
    .alu_command  (alu_command),
    .addr         (addr),
    .rs           (rs),
    .rt           (rt),
    .wselector    (wselector),
    .data         (data),
    .rd           (rd),
    .wenable      (wenable),
    .waddr        (waddr),
    .wdata        (wdata)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a,
                    input logic [31:0] d);
    wenable = 1'b1;
    waddr   = a;
    wdata   = d;
    tick();
    wenable = 1'b0;
    if (a != 5'd0) gpr[a] = d;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".done"}, 32'(done), 32'h0);
    chk({tag, ".exec"}, 32'(exec_command), 32'h0);
    chk({tag, ".alu"}, 32'(alu_command), 32'h0);
    chk({tag, ".addr"}, 32'(addr), 32'h0);
    chk({tag, ".rs"}, rs, 32'h0);
    chk({tag, ".rt"}, rt, 32'h0);
    chk({tag, ".wsel"}, 32'(wselector), 32'h0);
    chk({tag, ".data"}, data, 32'h0);
    chk({tag, ".rd"}, 32'(rd), 32'h0);
  endtask

  // Reference: instruction semantics from the field rules.
  task automatic chk_model(input string tag,
                           input logic [31:0] ins);
    logic [5:0]  op;
    logic [31:0] sx;
    logic [31:0] ea;
    logic [31:0] e_data;
    logic [28:0] e_addr;
    logic [1:0]  e_ws;
    logic [4:0]  e_rd;
    logic [5:0]  e_alu;
    op = ins[31:26];
    sx = {{16{ins[15]}}, ins[15:0]};
    ea = gpr[ins[25:21]] + sx;
    e_data = 32'h0;
    e_addr = 29'h0;
    e_ws   = 2'b00;
    e_rd   = 5'd0;
    e_alu  = (op == 6'h00) ? ins[5:0] : 6'h0;
    if (op == 6'h00) begin
      e_ws = 2'b01;
      e_rd = ins[15:11];
    end else if (op == 6'h02 || op == 6'h03) begin
      e_addr = {3'b000, ins[25:0]};
      if (op == 6'h03) begin
        e_ws = 2'b11;
        e_rd = 5'd31;
      end
    end else if (op inside {6'h01, [6'h04:6'h07]}) begin
      e_data = sx;
      e_addr = sx[28:0];
    end else if (op inside {[6'h08:6'h0F]}) begin
      e_data = (op >= 6'h0C) ? {16'h0, ins[15:0]} : sx;
      e_ws   = 2'b10;
      e_rd   = ins[20:16];
    end else if (op inside {6'h20, 6'h21, 6'h23,
                            6'h24, 6'h25}) begin
      e_data = sx;
      e_addr = ea[28:0];
      e_ws   = 2'b10;
      e_rd   = ins[20:16];
    end else if (op inside {6'h28, 6'h29, 6'h2B}) begin
      e_data = sx;
      e_addr = ea[28:0];
    end
    chk({tag, ".exec"}, 32'(exec_command), 32'(op));
    chk({tag, ".alu"}, 32'(alu_command), 32'(e_alu));
    chk({tag, ".addr"}, 32'(addr), 32'(e_addr));
    chk({tag, ".rs"}, rs, gpr[ins[25:21]]);
    chk({tag, ".rt"}, rt, gpr[ins[20:16]]);
    chk({tag, ".wsel"}, 32'(wselector), 32'(e_ws));
    chk({tag, ".data"}, data, e_data);
    chk({tag, ".rd"}, 32'(rd), 32'(e_rd));
  endtask

  // Full decode: optional write during READ and enable poke.
  task automatic run(input string tag,
                     input logic [31:0] ins,
                     input bit byp,
                     input logic [4:0] ba,
                     input logic [31:0] bd,
                     input bit poke);
    enable = 1'b1;
    instr  = ins;
    tick();
    enable = 1'b0;
    if (byp) begin
      wenable = 1'b1;
      waddr   = ba;
      wdata   = bd;
    end
    if (poke) begin
      enable = 1'b1;
      instr  = 32'h0000_0820;
    end
    chk({tag, ".early"}, 32'(done), 32'h0);
    tick();
    wenable = 1'b0;
    enable  = 1'b0;
    if (byp && ba != 5'd0) gpr[ba] = bd;
    chk({tag, ".done"}, 32'(done), 32'h1);
    chk_model(tag, ins);
    tick();
    chk({tag, ".pulse"}, 32'(done), 32'h0);
    chk({tag, ".hold"}, 32'(exec_command), 32'(ins[31:26]));
    if (poke) begin
      tick();
      chk({tag, ".poke1"}, 32'(done), 32'h0);
      tick();
      chk({tag, ".poke2"}, 32'(done), 32'h0);
    end
  endtask

  initial begin
    logic [5:0]  ops [24];
    logic [31:0] r;
    logic [31:0] ins;
    ops = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05,
            6'h06, 6'h07, 6'h08, 6'h09, 6'h0A, 6'h0B,
            6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h20, 6'h21,
            6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B};
    for (int i = 0; i < 32; i++) gpr[i] = 32'h0;
    rstn    = 1'b0;
    enable  = 1'b1;
    instr   = 32'h0C00_0001;
    wenable = 1'b0;
    waddr   = 5'd0;
    wdata   = 32'h0;
    tick();
    tick();
    rstn   = 1'b1;
    enable = 1'b0;
    chk_zero("reset");
    tick();
    tick();
    chk({"reset.drop"}, 32'(done), 32'h0);

    run("add", 32'h0022_1820, 1'b0, 5'd0, 32'h0, 1'b0);
    chk("add.rd", 32'(rd), 32'd3);
    chk("add.alu", 32'(alu_command), 32'h20);

    wr(5'd1, 32'h10);
    run("lw", 32'h8C22_FFFC, 1'b0, 5'd0, 32'h0, 1'b0);
    chk("lw.addr", 32'(addr), 32'h0C);
    chk("lw.data", data, 32'hFFFF_FFFC);

    run("ori", 32'h34A6_8000, 1'b1, 5'd5,
        32'hDEAD_BEEF, 1'b0);
    chk("ori.rs", rs, 32'hDEAD_BEEF);
    chk("ori.data", data, 32'h0000_8000);

    wr(5'd0, 32'h1234);
    run("r0", 32'h0000_3820, 1'b0, 5'd0, 32'h0, 1'b0);
    chk("r0.rs", rs, 32'h0);

    run("jal", 32'h0FFF_FFFF, 1'b0, 5'd0, 32'h0, 1'b1);
    chk("jal.addr", 32'(addr), 32'h03FF_FFFF);

    run("unk", 32'hFC21_1234, 1'b0, 5'd0, 32'h0, 1'b0);

    enable = 1'b1;
    instr  = 32'h8C22_FFFC;
    tick();
    enable = 1'b0;
    rstn   = 1'b0;
    tick();
    rstn   = 1'b1;
    chk_zero("midrst");
    for (int i = 0; i < 32; i++) gpr[i] = 32'h0;
    tick();
    chk("midrst.idle", 32'(done), 32'h0);
    run("postrst", 32'h34A6_0001, 1'b0, 5'd0, 32'h0, 1'b0);
    chk("postrst.rs", rs, 32'h0);

    for (int i = 0; i < 8; i++) begin
      r = $urandom();
      wr(5'($urandom_range(31)), r);
    end
    for (int i = 0; i < 40; i++) begin
      r   = $urandom();
      ins = {ops[$urandom_range(23)], r[25:0]};
      if ($urandom_range(3) == 0) begin
        r = $urandom();
        wr(5'($urandom_range(31)), r);
      end
      r = $urandom();
      run("rand", ins, ($urandom_range(2) == 0),
          5'($urandom_range(31)), r,
          ($urandom_range(5) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
